time_counter: RTL

- Downstream consumer of the clock-domain timer's end-of-period pulse.
- Each accepted tick advances a seconds/minutes/hours time-of-day register set, with cascaded carries and a day-wrap pulse.
- Supports hold, synchronous clear and per-field load for setting the time.
- Outputs feed the display/formatting stage.

---
 rtl/time_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: seconds/minutes/hours time-of-day counter advanced by accepted ticks,
// with hold, clear and per-field load; wrap pulses feed the display stage.
module time_counter #(
  parameter int p_sec_max = 60,
  parameter int p_min_max = 60,
  parameter int p_hour_max = 24,
  localparam int lp_sec_w = $clog2(p_sec_max),
  localparam int lp_min_w = $clog2(p_min_max),
  localparam int lp_hour_w = $clog2(p_hour_max),
  localparam int lp_sm_w = (lp_sec_w > lp_min_w) ? lp_sec_w : lp_min_w,
  localparam int lp_val_w = (lp_sm_w > lp_hour_w) ? lp_sm_w : lp_hour_w
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_stop,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [1:0]           i_field,
  input  logic [lp_val_w-1:0]  i_value,
  output logic [lp_sec_w-1:0]  o_sec,
  output logic [lp_min_w-1:0]  o_min,
  output logic [lp_hour_w-1:0] o_hour,
  output logic                 o_min_tick,
  output logic                 o_hour_tick,
  output logic                 o_day,
  output logic                 o_err,
  output logic                 o_running
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t r_state, w_next;
  logic [lp_sec_w-1:0] r_sec;
  logic [lp_min_w-1:0] r_min;
  logic [lp_hour_w-1:0] r_hour;
  logic r_min_tick, r_hour_tick, r_day, r_err;
  logic w_tick, w_load_ok, w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [31:0] w_val;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= RUN;
    else r_state <= w_next;
  end
  // Range check uses the full zero-extended load value, never a truncated one.
  always_comb begin
    w_next = i_stop ? HOLD : RUN;
    w_val = 32'(i_value);
    w_tick = i_tick && (r_state == RUN) && !i_stop;
    w_load_ok = (i_field == 2'd0) ? (w_val < 32'(p_sec_max)) :
                (i_field == 2'd1) ? (w_val < 32'(p_min_max)) :
                (i_field == 2'd2) ? (w_val < 32'(p_hour_max)) : 1'b0;
    w_sec_wrap = r_sec == lp_sec_w'(p_sec_max - 1);
    w_min_wrap = r_min == lp_min_w'(p_min_max - 1);
    w_hour_wrap = r_hour == lp_hour_w'(p_hour_max - 1);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sec <= '0;
      r_min <= '0;
      r_hour <= '0;
      r_min_tick <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_min_tick <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day <= 1'b0;
      r_err <= 1'b0;
      if (i_clear) begin
        r_sec <= '0;
        r_min <= '0;
        r_hour <= '0;
      end else if (i_load) begin
        if (w_load_ok) begin
          if (i_field == 2'd0) r_sec <= lp_sec_w'(i_value);
          if (i_field == 2'd1) r_min <= lp_min_w'(i_value);
          if (i_field == 2'd2) r_hour <= lp_hour_w'(i_value);
        end else r_err <= 1'b1;
      end else if (w_tick) begin
        r_sec <= w_sec_wrap ? '0 : r_sec + 1'b1;
        if (w_sec_wrap) begin
          r_min_tick <= 1'b1;
          r_min <= w_min_wrap ? '0 : r_min + 1'b1;
          if (w_min_wrap) begin
            r_hour_tick <= 1'b1;
            r_hour <= w_hour_wrap ? '0 : r_hour + 1'b1;
            r_day <= w_hour_wrap;
          end
        end
      end
    end
  end
  assign o_sec = r_sec;
  assign o_min = r_min;
  assign o_hour = r_hour;
  assign o_min_tick = r_min_tick;
  assign o_hour_tick = r_hour_tick;
  assign o_day = r_day;
  assign o_err = r_err;
  assign o_running = (r_state == RUN);
endmodule
